// File: rtl/ifu_param.sv
// Instruction fetch unit: PC register, byte-addressed read-only instruction memory and IF/ID register.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_TRAP_EN.
module ifu_param #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_BYTES = 1024,
    parameter logic [31:0] TRAP_PC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_en,
    input  logic [31:0] br_pc,
    input  logic [15:0] br_imm,
    input  logic        jmp_en,
    input  logic [31:0] jmp_target,
    output logic [31:0] pc,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int unsigned AW = $clog2(IM_BYTES);

    if ((IM_BYTES < 16) || ((1 << AW) != IM_BYTES)) begin : g_bad_im_bytes
        $error("IM_BYTES must be a power of two and at least 16");
    end
    if (TRAP_PC[1:0] != 2'b00) begin : g_bad_trap_pc
        $error("TRAP_PC must be word aligned");
    end

    // Read-only; contents are loaded from outside before use.
    logic [7:0] im [IM_BYTES];

    logic [AW-1:0] a0, a1, a2, a3;
    logic [31:0]   fetch_word;
    logic [31:0]   pc_plus4;
    logic [31:0]   br_target;
    logic [31:0]   tgt;
    logic          redirect;

    logic [31:0] pc_d, id_ins_d, id_pc_d, id_pc4_d;
    logic        id_valid_d;

    assign a0 = pc[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign fetch_word = {im[a0], im[a1], im[a2], im[a3]};

    assign pc_plus4  = pc + 32'd4;
    assign br_target = br_pc + 32'd4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    // Branch wins over a simultaneous jump.
    assign tgt       = br_en ? br_target : jmp_target;
    assign redirect  = br_en | jmp_en;

`ifdef IFU_MISALIGN_TRAP_EN
    logic        fault_d;
    logic [31:0] fault_pc_d;
`endif

    always_comb begin
        pc_d       = pc;
        id_ins_d   = id_ins;
        id_pc_d    = id_pc;
        id_pc4_d   = id_pc4;
        id_valid_d = id_valid;
`ifdef IFU_MISALIGN_TRAP_EN
        fault_d    = fault;
        fault_pc_d = fault_pc;
`endif
        if (redirect) begin
            id_valid_d = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            if (tgt[1:0] != 2'b00) begin
                pc_d       = TRAP_PC;
                fault_d    = 1'b1;
                fault_pc_d = tgt;
            end else begin
                pc_d = tgt;
            end
`else
            pc_d = tgt & ~32'd3;
`endif
        end else if (!stall) begin
            id_ins_d   = fetch_word;
            id_pc_d    = pc;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
            pc_d       = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            id_ins   <= 32'd0;
            id_pc    <= 32'd0;
            id_pc4   <= 32'd0;
            id_valid <= 1'b0;
        end else begin
            pc       <= pc_d;
            id_ins   <= id_ins_d;
            id_pc    <= id_pc_d;
            id_pc4   <= id_pc4_d;
            id_valid <= id_valid_d;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault    <= 1'b0;
            fault_pc <= 32'd0;
        end else begin
            fault    <= fault_d;
            fault_pc <= fault_pc_d;
        end
    end
`else
    assign fault    = 1'b0;
    assign fault_pc = 32'd0;
`endif

endmodule

// File: tb/tb_ifu_param.sv
// Directed self-checking bench for ifu_param (RESET_PC = 0, IM_BYTES = 16).
// Expectations follow IFU_MISALIGN_TRAP_EN when that macro is defined for the build.
module tb_ifu_param;

    localparam logic [31:0] TRAP = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst, stall, br_en, jmp_en;
    logic [31:0] br_pc, jmp_target;
    logic [15:0] br_imm;
    logic [31:0] pc, id_ins, id_pc, id_pc4, fault_pc;
    logic        id_valid, fault;

    int checks = 0;
    int errors = 0;

    logic [7:0] init_bytes [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                                    8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    ifu_param #(
        .RESET_PC (32'h0000_0000),
        .IM_BYTES (16),
        .TRAP_PC  (TRAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_en      (br_en),
        .br_pc      (br_pc),
        .br_imm     (br_imm),
        .jmp_en     (jmp_en),
        .jmp_target (jmp_target),
        .pc         (pc),
        .id_ins     (id_ins),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid),
        .fault      (fault),
        .fault_pc   (fault_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic st(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                      input logic [31:0] e_ipc, input logic e_v);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".id_ins"}, id_ins, e_ins);
        chk({tag, ".id_pc"}, id_pc, e_ipc);
        chk({tag, ".id_pc4"}, id_pc4, e_ipc + 32'd4);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_v});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"}, pc, 32'd0);
        chk({tag, ".id_ins"}, id_ins, 32'd0);
        chk({tag, ".id_pc"}, id_pc, 32'd0);
        chk({tag, ".id_pc4"}, id_pc4, 32'd0);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, 32'd0);
        chk({tag, ".fault"}, {31'd0, fault}, 32'd0);
        chk({tag, ".fault_pc"}, fault_pc, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dut.im[i] = init_bytes[i];
        rst = 1'b1; stall = 1'b0; br_en = 1'b0; jmp_en = 1'b0;
        br_pc = 32'd0; br_imm = 16'd0; jmp_target = 32'd0;
        tick();
        tick();
        chk_reset("reset");

        // Sequential fetch from RESET_PC.
        rst = 1'b0;
        tick(); st("fetch0", 32'h4, 32'h1234_5678, 32'h0, 1'b1);
        tick(); st("fetch1", 32'h8, 32'h9ABC_DEF0, 32'h4, 1'b1);

        // Backward branch, then forward branch.
        br_en = 1'b1; br_pc = 32'h10; br_imm = 16'hFFFE;
        tick(); st("br_back", 32'hC, 32'h9ABC_DEF0, 32'h4, 1'b0);
        br_en = 1'b0;
        tick(); st("fetch_c", 32'h10, 32'h89AB_CDEF, 32'hC, 1'b1);
        br_en = 1'b1; br_imm = 16'h0003;
        tick(); st("br_fwd", 32'h20, 32'h89AB_CDEF, 32'hC, 1'b0);

        // Branch beats simultaneous jump; jump alone next cycle.
        br_pc = 32'h30; jmp_en = 1'b1; jmp_target = 32'h100;
        tick(); chk("br_over_jmp.pc", pc, 32'h40);
        br_en = 1'b0;
        tick(); chk("jmp.pc", pc, 32'h100);
        chk("jmp.id_valid", {31'd0, id_valid}, 32'd0);
        jmp_en = 1'b0;
        tick(); st("fetch_100", 32'h104, 32'h1234_5678, 32'h100, 1'b1);

        // Three-cycle stall holds everything; jump during stall redirects.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); st($sformatf("stall%0d", i), 32'h104, 32'h1234_5678, 32'h100, 1'b1);
        end
        jmp_en = 1'b1; jmp_target = 32'h8;
        tick(); st("stall_jmp", 32'h8, 32'h1234_5678, 32'h100, 1'b0);
        stall = 1'b0; jmp_en = 1'b0;
        tick(); st("fetch_8", 32'hC, 32'h0123_4567, 32'h8, 1'b1);

        // Misaligned jump target.
        jmp_en = 1'b1; jmp_target = 32'h102;
        tick();
`ifdef IFU_MISALIGN_TRAP_EN
        chk("mis.pc", pc, TRAP);
        chk("mis.fault", {31'd0, fault}, 32'd1);
        chk("mis.fault_pc", fault_pc, 32'h102);
`else
        chk("mis.pc", pc, 32'h100);
        chk("mis.fault", {31'd0, fault}, 32'd0);
        chk("mis.fault_pc", fault_pc, 32'd0);
`endif
        chk("mis.id_valid", {31'd0, id_valid}, 32'd0);
        jmp_en = 1'b0;
        tick();
`ifdef IFU_MISALIGN_TRAP_EN
        st("mis_after", TRAP + 32'd4, 32'h1234_5678, TRAP, 1'b1);
        chk("mis_after.fault", {31'd0, fault}, 32'd1);
`else
        st("mis_after", 32'h104, 32'h1234_5678, 32'h100, 1'b1);
        chk("mis_after.fault", {31'd0, fault}, 32'd0);
`endif

        // Last word of memory, then misaligned 0xE.
        jmp_en = 1'b1; jmp_target = 32'hC;
        tick(); chk("jmp_c.pc", pc, 32'hC);
        jmp_en = 1'b0;
        tick(); st("fetch_c2", 32'h10, 32'h89AB_CDEF, 32'hC, 1'b1);
        jmp_en = 1'b1; jmp_target = 32'hE;
        tick();
`ifdef IFU_MISALIGN_TRAP_EN
        chk("jmp_e.pc", pc, TRAP);
        chk("jmp_e.fault_pc", fault_pc, 32'hE);
`else
        chk("jmp_e.pc", pc, 32'hC);
`endif

        // PC wrap past 32'hFFFF_FFFC.
        jmp_target = 32'hFFFF_FFFC;
        tick(); chk("jmp_top.pc", pc, 32'hFFFF_FFFC);
        jmp_en = 1'b0;
        tick(); st("wrap", 32'h0, 32'h89AB_CDEF, 32'hFFFF_FFFC, 1'b1);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("wrap.fault", {31'd0, fault}, 32'd1);
`else
        chk("wrap.fault", {31'd0, fault}, 32'd0);
`endif

        // Reset wins over stall and redirect together.
        rst = 1'b1; stall = 1'b1; jmp_en = 1'b1; jmp_target = 32'h200;
        tick(); chk_reset("rst_mid");
        rst = 1'b0; stall = 1'b0; jmp_en = 1'b0;
        tick(); st("refetch", 32'h4, 32'h1234_5678, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
